// File: rtl/rr_arbiter_3.sv
// ---------------------------------------------------------------------------
// rr_arbiter_3
//
// Three-requester round-robin arbiter placed in front of the 3-bit-in /
// 2-bit-out encoder. A source keeps its req bit high for the whole
// transaction. The arbiter holds the grant until the owner drops its request.
// The rotation pointer ensures that no requester waits behind more than two
// other grants.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   3  request per source
//   gnt        out  3  registered one-hot grant, all-zero when idle
//   gnt_idx    out  2  encoded owner (00/01/10), 2'b11 when no owner
//   gnt_valid  out  1  high while any grant is active (equals |gnt)
//
// Parameters:
//   MAX_HOLD   cycles an owner may hold while others wait (legal 2..2^CNT_W)
//   CNT_W      width of the hold counter
//
// Optional build macro:
//   TIMEOUT_EN  when defined, an owner whose hold counter has saturated at
//               MAX_HOLD-1 is preempted as soon as another request is
//               pending. When undefined, the counter still runs and
//               saturates, but it never affects the grant.
// ---------------------------------------------------------------------------
module rr_arbiter_3 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);
  localparam logic [1:0]       IDX_NONE = 2'b11;

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] others;
  logic       owner_req;
  logic       timeout_hit;

  // Successor of a source index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_mod3(input logic [1:0] i);
    next_mod3 = (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Returns the first set bit of mask, searching start, start+1, start+2
  // (mod 3). Returns 2'b11 when the mask is empty.
  function automatic logic [1:0] pick(input logic [2:0] mask,
                                      input logic [1:0] start);
    logic [1:0] first, second, third;
    first  = start;
    second = next_mod3(start);
    third  = next_mod3(second);
    if (mask[first])       pick = first;
    else if (mask[second]) pick = second;
    else if (mask[third])  pick = third;
    else                   pick = 2'b11;
  endfunction

  assign others    = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);

`ifdef TIMEOUT_EN
  assign timeout_hit = (cnt_q == CNT_MAX) && (|others);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic. Every new grant loads the grant, index, pointer and
  // counter together. This keeps gnt and gnt_idx consistent at every edge.
  always_comb begin
    logic       do_grant;
    logic [1:0] win_idx;

    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    do_grant = 1'b0;
    win_idx  = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          win_idx  = pick(req, ptr_q);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // The owner released. Hand off at this same edge if anyone else
          // is waiting. The search starts after the owner and excludes it.
          if (|others) begin
            do_grant = 1'b1;
            win_idx  = pick(others, next_mod3(idx_q));
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            idx_d   = IDX_NONE;
          end
        end else if (timeout_hit) begin
          do_grant = 1'b1;
          win_idx  = pick(others, next_mod3(idx_q));
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_grant) begin
      state_d = GRANT;
      gnt_d   = 3'(3'b001 << win_idx);
      idx_d   = win_idx;
      ptr_d   = next_mod3(win_idx);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      idx_q   <= IDX_NONE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter_3.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_3
//
// Self-checking bench for rr_arbiter_3. Each step drives req on the falling
// edge and pushes the grant expected after the next rising edge into a
// queue. That expectation is popped and compared 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_3;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int checks;
  int failures;

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] idx;
    string      name;
  } exp_t;

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] idx;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[29];

  rr_arbiter_3 #(
    .MAX_HOLD(8),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops the oldest expectation and compares it with what the DUT shows now.
  task automatic checkOutput();
    exp_t e;
    logic exp_valid;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty: nothing expected, got gnt=%b idx=%b", gnt, gnt_idx);
      return;
    end
    e = exp_q.pop_front();
    exp_valid = (e.gnt != 3'b000);
    if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== exp_valid) begin
      failures++;
      $display("[TB] FAIL %s: got gnt=%b idx=%b valid=%b, expected gnt=%b idx=%b valid=%b",
               e.name, gnt, gnt_idx, gnt_valid, e.gnt, e.idx, exp_valid);
    end
  endtask

  // Drives one request pattern, queues the expected grant, and checks it
  // after the next rising edge.
  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] eg,
                               input logic [1:0] ei, input string name);
    exp_t e;
    @(negedge clk);
    req = r;
    e.gnt  = eg;
    e.idx  = ei;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    failures = 0;
    req      = 3'b000;
    rst_n    = 1'b0;

    // {req, expected gnt, expected idx} after each edge, starting with ptr=0
    vecs[0]  = '{3'b000, 3'b000, 2'b11};  // idle stays idle
    vecs[1]  = '{3'b100, 3'b100, 2'b10};  // single requester 2
    vecs[2]  = '{3'b000, 3'b000, 2'b11};  // release -> idle, ptr=0
    vecs[3]  = '{3'b111, 3'b001, 2'b00};  // round robin: 0 first
    vecs[4]  = '{3'b111, 3'b001, 2'b00};
    vecs[5]  = '{3'b111, 3'b001, 2'b00};
    vecs[6]  = '{3'b110, 3'b010, 2'b01};  // 0 drops -> 1, no bubble
    vecs[7]  = '{3'b111, 3'b010, 2'b01};
    vecs[8]  = '{3'b111, 3'b010, 2'b01};
    vecs[9]  = '{3'b101, 3'b100, 2'b10};  // 1 drops -> 2
    vecs[10] = '{3'b111, 3'b100, 2'b10};
    vecs[11] = '{3'b111, 3'b100, 2'b10};
    vecs[12] = '{3'b011, 3'b001, 2'b00};  // 2 drops -> 0, ptr=1
    vecs[13] = '{3'b000, 3'b000, 2'b11};  // idle, ptr stays 1
    vecs[14] = '{3'b101, 3'b100, 2'b10};  // pointer skip: 2 beats 0
    vecs[15] = '{3'b000, 3'b000, 2'b11};  // ptr=0
    vecs[16] = '{3'b010, 3'b010, 2'b01};  // 1 owns, ptr=2
    vecs[17] = '{3'b011, 3'b010, 2'b01};  // late joiner 0 waits
    vecs[18] = '{3'b001, 3'b001, 2'b00};  // 1 drops, 2 absent -> 0
    vecs[19] = '{3'b000, 3'b000, 2'b11};  // ptr=1
    vecs[20] = '{3'b010, 3'b010, 2'b01};  // 1 owns, ptr=2
    vecs[21] = '{3'b111, 3'b010, 2'b01};  // 0 and 2 join
    vecs[22] = '{3'b101, 3'b100, 2'b10};  // 2 served before 0
    vecs[23] = '{3'b001, 3'b001, 2'b00};  // then 0
    vecs[24] = '{3'b000, 3'b000, 2'b11};  // ptr=1
    vecs[25] = '{3'b110, 3'b010, 2'b01};  // 1 wins, ptr=2
    vecs[26] = '{3'b010, 3'b010, 2'b01};  // 2 withdraws while waiting
    vecs[27] = '{3'b001, 3'b001, 2'b00};  // 2 skipped, 0 served
    vecs[28] = '{3'b000, 3'b000, 2'b11};  // ptr=1

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    e = '{3'b000, 2'b11, "reset_state"};
    exp_q.push_back(e);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      applyStimulus(vecs[i].req, vecs[i].gnt, vecs[i].idx, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a grant (ptr=1, so source 1 wins)
    applyStimulus(3'b010, 3'b010, 2'b01, "pre_reset_grant");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    e = '{3'b000, 2'b11, "async_reset_mid_grant"};
    exp_q.push_back(e);
    checkOutput();
    req = 3'b111;
    @(posedge clk);
    #1;
    e = '{3'b000, 2'b11, "held_in_reset"};
    exp_q.push_back(e);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = '{3'b001, 2'b00, "after_reset_ptr0"};
    exp_q.push_back(e);
    checkOutput();

    // Give source 0 the grant from ptr=1 (1 and 2 are idle), then make
    // source 1 wait behind it
    applyStimulus(3'b000, 3'b000, 2'b11, "to_idle");
    applyStimulus(3'b000, 3'b000, 2'b11, "idle_ptr1");
    applyStimulus(3'b001, 3'b001, 2'b00, "hold_start");
`ifdef TIMEOUT_EN
    for (int i = 1; i <= 10; i++) begin
      if (i < 8) applyStimulus(3'b011, 3'b001, 2'b00, $sformatf("hold_cycle%0d", i));
      else       applyStimulus(3'b011, 3'b010, 2'b01, $sformatf("preempted%0d", i));
    end
`else
    for (int i = 1; i < 50; i++) begin
      applyStimulus(3'b011, 3'b001, 2'b00, $sformatf("hold_cycle%0d", i));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_3.md
Name: rr_arbiter_3

Overview:
- Three-requester round-robin arbiter that shares the 3-bit-in / 2-bit-out encoder datapath between three sources.
- Produces a registered one-hot grant plus its 2-bit encoded index, which matches the encoder's output width.
- The grant is held until the owner releases it; rotation prevents starvation.
- Sits in front of the encoder; its gnt drives the encoder's 3-bit input bus.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant while another request is pending (TIMEOUT_EN only); legal range 2..2^CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  3  request per source; a source holds it high for the whole transaction
- gnt  output  3  one-hot grant, registered; all-zero when idle
- gnt_idx  output  2  encoded owner: 2'b00/01/10 = source 0/1/2; 2'b11 = none
- gnt_valid  output  1  high when any grant is active (equals |gnt)

Behaviour:
- Reset (async, rst_n=0):
  - gnt=3'b000, gnt_idx=2'b11, gnt_valid=0.
  - State=IDLE, rotation pointer ptr=0, hold counter=0.
  - Effective immediately, including mid-grant; on release, arbitration resumes from ptr=0.
- State IDLE:
  - On a clk edge with req!=0, grant the first set req bit searching ptr, ptr+1, ptr+2 (mod 3).
  - Go to GRANT; outputs update at that edge, so latency is 1 cycle from req sampled to gnt.
- State GRANT (owner o):
  - Owner keeps req[o]=1: hold grant; counter increments.
  - Owner drops req[o] (sampled 0 at an edge), other requests pending: grant the next winner at that same edge. Search starts at o+1 (mod 3) and excludes o, so there is no idle bubble.
  - Owner drops req[o], no other requests: go to IDLE; gnt=0, gnt_idx=2'b11 at that edge.
- Pointer: ptr <= winner+1 (mod 3) at every new grant; ptr keeps its value in IDLE.
- Hold counter: cleared to 0 on every new grant; increments while the grant is held; saturates at MAX_HOLD-1.
- gnt and gnt_idx always change at the same edge and are always consistent.
- Requests from non-owners never affect the current grant, except via the timeout.
- The encoding must never produce 2'b11 while gnt_valid=1.
- Simultaneous requests: a single winner per the pointer order; losers wait. A requester waits at most 2 other grants before being served.
- req bits may rise or fall in any cycle. A non-owner that drops req before being granted is simply skipped.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined:
  - When the counter is at MAX_HOLD-1, the owner still requests, and another req is pending, preempt at the next edge.
  - The grant passes to the next winner from o+1 (o excluded), the counter clears, and ptr updates.
  - With no other request pending, the owner keeps the grant and the counter stays saturated, so preemption occurs at the first edge another request is seen.
- Undefined:
  - No preemption; the owner holds indefinitely.
  - The counter is still present and saturating, but it has no effect on grants.

Test Plan:
- Reset: assert rst_n=0 mid-grant (gnt=3'b010) -> gnt=000, gnt_idx=11, gnt_valid=0 immediately. After release, req=3'b111 -> gnt=001, gnt_idx=00 one cycle later.
- Single requester: req=3'b100 from IDLE -> gnt=100, idx=10 after 1 edge. Drop req -> gnt=000, idx=11 after 1 edge.
- Round robin: hold req=3'b111, with each owner dropping its bit for one cycle after 3 cycles -> grant order 0,1,2,0, each handoff with no idle cycle.
- Pointer skip: ptr=1 after a grant to source 0; req=3'b101 -> source 2 granted (idx=10), not source 0.
- Late joiner: source 1 owns; source 0 asserts -> source 0 waits. After source 1 releases, source 0 is granted only if source 2 is not requesting; otherwise source 2 first, then source 0.
- TIMEOUT_EN with MAX_HOLD=8: source 0 holds req while source 1 requests -> gnt moves to 010 at exactly the 8th cycle of source 0's grant. Without the macro, source 0 keeps gnt=001 for 50 cycles.
